// File: rtl/pcie_rx_stream_adapter_pkg.sv
// Shared widths, constants and types for the PCIe receive stream adapter.
package pcie_rx_stream_adapter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BAR_W  = 7;
    localparam int unsigned KEEP_W = 4;
    localparam int unsigned CNT_W  = 16;

    localparam logic [KEEP_W-1:0] KEEP_ALL = 4'hF;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        IN_PKT   = 2'd1,
        DISCARD  = 2'd2
    } wr_state_e;

    // One data buffer entry: the word plus its end-of-frame marker
    typedef struct packed {
        logic              eof;
        logic [DATA_W-1:0] data;
    } buf_entry_t;

endpackage

// File: rtl/pcie_rx_stream_adapter_small_fifo.sv
// Generic synchronous first-word-fall-through FIFO with full/empty/count.
module pcie_rx_stream_adapter_small_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; push into a full or pop from an empty FIFO is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PW'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pcie_rx_stream_adapter.sv
// Store-and-forward TRN receive front end: buffers whole TLPs, drops bad ones,
// and presents only committed packets as an AXI-stream with a BAR-hit vector.
module pcie_rx_stream_adapter
    import pcie_rx_stream_adapter_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned BAR_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_trn_rd,
    input  logic              i_trn_rsof_n,
    input  logic              i_trn_reof_n,
    input  logic              i_trn_rsrc_rdy_n,
    output logic              o_trn_rdst_rdy_n,
    input  logic              i_trn_rerrfwd_n,
    input  logic              i_trn_rsrc_dsc_n,
    input  logic [BAR_W-1:0]  i_trn_rbar_hit_n,
    output logic [DATA_W-1:0] o_axi_ingress_data,
    output logic [KEEP_W-1:0] o_axi_ingress_keep,
    output logic              o_axi_ingress_last,
    output logic              o_axi_ingress_valid,
    input  logic              i_axi_ingress_ready,
    output logic [BAR_W-1:0]  o_bar_hit,
    output logic [CNT_W-1:0]  o_pkt_count,
    output logic [CNT_W-1:0]  o_drop_count
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned BCW = $clog2(BAR_DEPTH) + 1;

    wr_state_e        state, state_nxt;
    logic [PW-1:0]    wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]    commit_ptr, commit_ptr_nxt;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    pkt_len, pkt_len_nxt;
    logic [BAR_W-1:0] bar_lat, bar_lat_nxt;

    logic             beat_c, sof_c, eof_c, err_c, start_c;
    logic             mem_we_c, push_c, drop_c;
    logic [AW-1:0]    mem_waddr_c;
    logic [BAR_W-1:0] bar_push_c;

    buf_entry_t       mem [DEPTH];
    buf_entry_t       head_c;
    logic             valid_c, rd_fire_c, pop_c;
    logic [PW-1:0]    used_c;
    logic             rdy_n_nxt;

    logic [BAR_W-1:0] bar_head_c;
    logic             bar_full_c, bar_empty_c;
    logic [BCW-1:0]   bar_count_c;

    assign beat_c = !i_trn_rsrc_rdy_n && !o_trn_rdst_rdy_n;
    assign sof_c  = !i_trn_rsof_n;
    assign eof_c  = !i_trn_reof_n;
    assign err_c  = !i_trn_rerrfwd_n || !i_trn_rsrc_dsc_n;

    // Write-side decode: where the beat goes, whether the packet commits or is rewound
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        pkt_len_nxt    = pkt_len;
        bar_lat_nxt    = bar_lat;
        bar_push_c     = bar_lat;
        mem_we_c       = 1'b0;
        mem_waddr_c    = wr_ptr[AW-1:0];
        push_c         = 1'b0;
        drop_c         = 1'b0;
        start_c        = 1'b0;

        case (state)
            WAIT_SOF: begin
                if (beat_c) begin
                    if (!sof_c || err_c) begin
                        drop_c    = 1'b1;
                        state_nxt = eof_c ? WAIT_SOF : DISCARD;
                    end else begin
                        start_c = 1'b1;
                    end
                end
            end
            IN_PKT: begin
                if (beat_c) begin
                    if (err_c) begin
                        drop_c     = 1'b1;
                        wr_ptr_nxt = commit_ptr;
                        state_nxt  = eof_c ? WAIT_SOF : DISCARD;
                    end else if (sof_c) begin
                        // Partial packet abandoned; this word opens a new one
                        drop_c  = 1'b1;
                        start_c = 1'b1;
                    end else if (eof_c) begin
                        mem_we_c       = 1'b1;
                        wr_ptr_nxt     = wr_ptr + PW'(1);
                        commit_ptr_nxt = wr_ptr + PW'(1);
                        push_c         = 1'b1;
                        state_nxt      = WAIT_SOF;
                    end else if (pkt_len == PW'(DEPTH - 2)) begin
                        // Word DEPTH-1 without EOF: packet can never fit, stop buffering it
                        drop_c     = 1'b1;
                        wr_ptr_nxt = commit_ptr;
                        state_nxt  = DISCARD;
                    end else begin
                        mem_we_c    = 1'b1;
                        wr_ptr_nxt  = wr_ptr + PW'(1);
                        pkt_len_nxt = pkt_len + PW'(1);
                    end
                end
            end
            DISCARD: begin
                if ((beat_c && eof_c) || !i_trn_rsrc_dsc_n) state_nxt = WAIT_SOF;
            end
            default: state_nxt = WAIT_SOF;
        endcase

        // First word of a packet always lands at the commit point
        if (start_c) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = commit_ptr[AW-1:0];
            bar_lat_nxt = ~i_trn_rbar_hit_n;
            bar_push_c  = ~i_trn_rbar_hit_n;
            pkt_len_nxt = PW'(1);
            if (eof_c) begin
                wr_ptr_nxt     = commit_ptr + PW'(1);
                commit_ptr_nxt = commit_ptr + PW'(1);
                push_c         = 1'b1;
                state_nxt      = WAIT_SOF;
            end else begin
                wr_ptr_nxt = commit_ptr + PW'(1);
                state_nxt  = IN_PKT;
            end
        end
    end

    // Backpressure from pre-update occupancy; the 2-entry margin covers the beat in flight
    assign used_c    = wr_ptr - rd_ptr;
    assign rdy_n_nxt = (state_nxt != DISCARD) &&
                       ((used_c >= PW'(DEPTH - 2)) ||
                        (bar_count_c >= BCW'(BAR_DEPTH - 1)) || bar_full_c);

    // Read side: first-word-fall-through from the committed region only
    assign valid_c   = (rd_ptr != commit_ptr);
    assign head_c    = mem[rd_ptr[AW-1:0]];
    assign rd_fire_c = valid_c && i_axi_ingress_ready;
    assign pop_c     = rd_fire_c && head_c.eof;

    assign o_axi_ingress_valid = valid_c;
    assign o_axi_ingress_data  = valid_c ? head_c.data : '0;
    assign o_axi_ingress_last  = valid_c && head_c.eof;
    assign o_axi_ingress_keep  = KEEP_ALL;
    assign o_bar_hit           = (valid_c && !bar_empty_c) ? bar_head_c : '0;

    // FSM, pointers, flow control and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= WAIT_SOF;
            wr_ptr           <= '0;
            commit_ptr       <= '0;
            rd_ptr           <= '0;
            pkt_len          <= '0;
            bar_lat          <= '0;
            o_trn_rdst_rdy_n <= 1'b1;
            o_pkt_count      <= '0;
            o_drop_count     <= '0;
        end else begin
            state            <= state_nxt;
            wr_ptr           <= wr_ptr_nxt;
            commit_ptr       <= commit_ptr_nxt;
            rd_ptr           <= rd_ptr + PW'(rd_fire_c);
            pkt_len          <= pkt_len_nxt;
            bar_lat          <= bar_lat_nxt;
            o_trn_rdst_rdy_n <= rdy_n_nxt;
            o_pkt_count      <= o_pkt_count + CNT_W'(push_c);
            o_drop_count     <= o_drop_count + CNT_W'(drop_c);
        end
    end

    // Packet data storage
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[mem_waddr_c] <= '{eof: eof_c, data: i_trn_rd};
    end

    pcie_rx_stream_adapter_small_fifo #(
        .WIDTH (BAR_W),
        .DEPTH (BAR_DEPTH)
    ) u_bar_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .din   (bar_push_c),
        .pop   (pop_c),
        .dout  (bar_head_c),
        .full  (bar_full_c),
        .empty (bar_empty_c),
        .count (bar_count_c)
    );

endmodule

// File: tb/tb_pcie_rx_stream_adapter.sv
// Directed bench for pcie_rx_stream_adapter with a word-level scoreboard.
module tb_pcie_rx_stream_adapter;

    localparam int unsigned DEPTH     = 64;
    localparam int unsigned BAR_DEPTH = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [6:0]  bar;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_trn_rd;
    logic        i_trn_rsof_n;
    logic        i_trn_reof_n;
    logic        i_trn_rsrc_rdy_n;
    logic        o_trn_rdst_rdy_n;
    logic        i_trn_rerrfwd_n;
    logic        i_trn_rsrc_dsc_n;
    logic [6:0]  i_trn_rbar_hit_n;
    logic [31:0] o_axi_ingress_data;
    logic [3:0]  o_axi_ingress_keep;
    logic        o_axi_ingress_last;
    logic        o_axi_ingress_valid;
    logic        i_axi_ingress_ready;
    logic [6:0]  o_bar_hit;
    logic [15:0] o_pkt_count;
    logic [15:0] o_drop_count;

    int   total = 0;
    int   bad = 0;
    int   beats_acc = 0;
    int   stall_cycles = 0;
    bit   sender_done = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    pcie_rx_stream_adapter #(
        .DEPTH     (DEPTH),
        .BAR_DEPTH (BAR_DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_trn_rd            (i_trn_rd),
        .i_trn_rsof_n        (i_trn_rsof_n),
        .i_trn_reof_n        (i_trn_reof_n),
        .i_trn_rsrc_rdy_n    (i_trn_rsrc_rdy_n),
        .o_trn_rdst_rdy_n    (o_trn_rdst_rdy_n),
        .i_trn_rerrfwd_n     (i_trn_rerrfwd_n),
        .i_trn_rsrc_dsc_n    (i_trn_rsrc_dsc_n),
        .i_trn_rbar_hit_n    (i_trn_rbar_hit_n),
        .o_axi_ingress_data  (o_axi_ingress_data),
        .o_axi_ingress_keep  (o_axi_ingress_keep),
        .o_axi_ingress_last  (o_axi_ingress_last),
        .o_axi_ingress_valid (o_axi_ingress_valid),
        .i_axi_ingress_ready (i_axi_ingress_ready),
        .o_bar_hit           (o_bar_hit),
        .o_pkt_count         (o_pkt_count),
        .o_drop_count        (o_drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_trn();
        i_trn_rd         = 32'h0;
        i_trn_rsof_n     = 1'b1;
        i_trn_reof_n     = 1'b1;
        i_trn_rsrc_rdy_n = 1'b1;
        i_trn_rerrfwd_n  = 1'b1;
        i_trn_rsrc_dsc_n = 1'b1;
        i_trn_rbar_hit_n = 7'h7F;
    endtask

    // Offer one word at a negedge and hold it until the adapter takes it
    task automatic send(input logic [31:0] d, input bit sof, input bit eof,
                        input logic [6:0] bar_n, input bit err);
        int guard = 0;
        i_trn_rd         = d;
        i_trn_rsof_n     = !sof;
        i_trn_reof_n     = !eof;
        i_trn_rbar_hit_n = bar_n;
        i_trn_rerrfwd_n  = !err;
        i_trn_rsrc_rdy_n = 1'b0;
        while (o_trn_rdst_rdy_n) begin
            @(negedge clk);
            stall_cycles++;
            guard++;
            if (guard > 5000) begin
                total++;
                bad++;
                $display("FAIL send_timeout observed=stalled expected=accepted");
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "sender stuck");
            end
        end
        @(negedge clk);
        idle_trn();
    endtask

    task automatic send_pkt(input int len, input logic [31:0] base, input logic [6:0] bar_n,
                            input int err_at, input bit with_eof, input bit good);
        for (int i = 1; i <= len; i++) begin
            if (good) exp_q.push_back(exp_t'({base + 32'(i), 1'(i == len), ~bar_n}));
            send(base + 32'(i), i == 1, with_eof && (i == len), bar_n, i == err_at);
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || o_axi_ingress_valid) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rdst_rdy_n"}, 64'(o_trn_rdst_rdy_n), 64'(1));
        chk({tag, "_valid"}, 64'(o_axi_ingress_valid), 64'(0));
        chk({tag, "_last"}, 64'(o_axi_ingress_last), 64'(0));
        chk({tag, "_data"}, 64'(o_axi_ingress_data), 64'(0));
        chk({tag, "_bar"}, 64'(o_bar_hit), 64'(0));
        chk({tag, "_pkt_count"}, 64'(o_pkt_count), 64'(0));
        chk({tag, "_drop_count"}, 64'(o_drop_count), 64'(0));
    endtask

    // Beat counter and output scoreboard, sampled just before each rising edge
    always begin
        @(negedge clk);
        #4;
        if (!i_trn_rsrc_rdy_n && !o_trn_rdst_rdy_n) beats_acc++;
        if (o_axi_ingress_valid && i_axi_ingress_ready) begin
            chk("rd_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("rd_word", 64'({o_axi_ingress_data, o_axi_ingress_last, o_bar_hit}), 64'(mon_e));
            end
        end
    end

    initial begin
        int acc0;
        int guard;
        rst = 1'b1;
        idle_trn();
        i_axi_ingress_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        chk("reset_keep", 64'(o_axi_ingress_keep), 64'(4'hF));
        rst = 1'b0;
        i_axi_ingress_ready = 1'b1;

        // 3-word TLP: valid appears the cycle after the EOF beat
        exp_q.push_back(exp_t'({32'h1001, 1'b0, 7'h01}));
        exp_q.push_back(exp_t'({32'h1002, 1'b0, 7'h01}));
        exp_q.push_back(exp_t'({32'h1003, 1'b1, 7'h01}));
        send(32'h1001, 1'b1, 1'b0, 7'b1111110, 1'b0);
        send(32'h1002, 1'b0, 1'b0, 7'b1111110, 1'b0);
        chk("t1_valid_before_eof", 64'(o_axi_ingress_valid), 64'(0));
        send(32'h1003, 1'b0, 1'b1, 7'b1111110, 1'b0);
        chk("t1_valid_eof_plus1", 64'(o_axi_ingress_valid), 64'(1));
        chk("t1_bar_hit", 64'(o_bar_hit), 64'(7'h01));
        chk("t1_first_data", 64'(o_axi_ingress_data), 64'(32'h1001));
        wait_drain();
        chk("t1_pkt_count", 64'(o_pkt_count), 64'(1));

        // Poisoned TLP is dropped, the next clean one passes
        send_pkt(4, 32'h2000, 7'b1111101, 2, 1'b1, 1'b0);
        chk("t2_no_valid", 64'(o_axi_ingress_valid), 64'(0));
        chk("t2_drop_count", 64'(o_drop_count), 64'(1));
        send_pkt(3, 32'h2100, 7'b1111011, 0, 1'b1, 1'b1);
        wait_drain();
        chk("t2_pkt_count", 64'(o_pkt_count), 64'(2));

        // Backpressure: 30 + 40 words offered with the consumer stalled
        i_axi_ingress_ready = 1'b0;
        acc0 = beats_acc;
        sender_done = 1'b0;
        fork
            begin
                send_pkt(30, 32'h3000, 7'b1110111, 0, 1'b1, 1'b1);
                send_pkt(40, 32'h3100, 7'b1101111, 0, 1'b1, 1'b1);
                sender_done = 1'b1;
            end
        join_none
        guard = 0;
        while (!o_trn_rdst_rdy_n && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("t3_rdst_rdy_n_rises", 64'(o_trn_rdst_rdy_n), 64'(1));
        // Raised once 62 entries were in use; the beat already in flight makes 63
        chk("t3_words_at_rise", 64'(beats_acc - acc0), 64'(63));
        repeat (10) @(negedge clk);
        chk("t3_words_held", 64'(beats_acc - acc0), 64'(63));
        chk("t3_still_stalled", 64'(o_trn_rdst_rdy_n), 64'(1));
        chk("t3_first_pkt_visible", 64'(o_axi_ingress_valid), 64'(1));
        i_axi_ingress_ready = 1'b1;
        guard = 0;
        while (!sender_done && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("t3_sender_done", 64'(sender_done), 64'(1));
        wait_drain();
        chk("t3_pkt_count", 64'(o_pkt_count), 64'(4));

        // Oversized 64-word TLP: dropped without ever backpressuring
        stall_cycles = 0;
        send_pkt(64, 32'h4000, 7'b1111110, 0, 1'b1, 1'b0);
        chk("t4_no_stall", 64'(stall_cycles), 64'(0));
        chk("t4_no_valid", 64'(o_axi_ingress_valid), 64'(0));
        chk("t4_drop_count", 64'(o_drop_count), 64'(2));
        send_pkt(5, 32'h4100, 7'b0111111, 0, 1'b1, 1'b1);
        wait_drain();
        chk("t4_pkt_count", 64'(o_pkt_count), 64'(5));

        // SOF in mid-packet: partial one dropped, new one delivered with its BAR
        send_pkt(3, 32'h5000, 7'b1111101, 0, 1'b0, 1'b0);
        send_pkt(4, 32'h5100, 7'b1011111, 0, 1'b1, 1'b1);
        wait_drain();
        chk("t5_drop_count", 64'(o_drop_count), 64'(3));
        chk("t5_pkt_count", 64'(o_pkt_count), 64'(6));

        // Single-word TLP (SOF and EOF together)
        send_pkt(1, 32'h6000, 7'b0111111, 0, 1'b1, 1'b1);
        wait_drain();
        chk("t6_pkt_count", 64'(o_pkt_count), 64'(7));

        // Reset with a committed packet queued and another half received
        i_axi_ingress_ready = 1'b0;
        send_pkt(2, 32'h7000, 7'b1111110, 0, 1'b1, 1'b0);
        send_pkt(2, 32'h7100, 7'b1111110, 0, 1'b0, 1'b0);
        chk("t7_queued_valid", 64'(o_axi_ingress_valid), 64'(1));
        chk("t7_pkt_count", 64'(o_pkt_count), 64'(8));
        rst = 1'b1;
        @(negedge clk);
        chk_reset_values("t7_rst");
        rst = 1'b0;
        i_axi_ingress_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("t7_nothing_after", 64'(o_axi_ingress_valid), 64'(0));
        chk("t7_drop_after", 64'(o_drop_count), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
